// File: rtl/sprite_line_scheduler_if.sv
// Signal bundle between the sprite line scheduler, the sprite register bank,
// the beam timing source and the sprite address calculator.
interface sprite_line_scheduler_if #(
  parameter int unsigned SLOT_W = 5
) ();
  logic              line_start;
  logic [9:0]        line_y;
  logic [9:0]        pixel_x;
  logic [SLOT_W-1:0] slot_addr;
  logic [31:0]       slot_data;
  logic [31:0]       sprite_datas;
  logic              sprite_on;
  logic              counter_finished;
  logic              overflow;
  logic              busy;

  modport master (
    input  line_start, line_y, pixel_x, slot_data, counter_finished,
    output slot_addr, sprite_datas, sprite_on, overflow, busy
  );

  modport slave (
    output line_start, line_y, pixel_x, slot_data, counter_finished,
    input  slot_addr, sprite_datas, sprite_on, overflow, busy
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite sequencer: scans the sprite register file for sprites
// covering the announced line, buffers them, then hands them out one by one.
module sprite_line_scheduler #(
  parameter int unsigned NUM_SLOTS   = 32,
  parameter int unsigned SLOT_W      = 5,
  parameter int unsigned MAX_ACTIVE  = 4,
  parameter int unsigned SPRITE_SIZE = 20
) (
  input logic                     clk_pixel,
  input logic                     reset,
  sprite_line_scheduler_if.master bus
);
  localparam int unsigned CNT_W  = $clog2(MAX_ACTIVE + 1);
  localparam int unsigned IDX_W  = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;
  localparam int unsigned DEPTH  = 2 ** IDX_W;
  localparam int unsigned SCAN_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_t;

  state_t            state_q, state_n;
  logic [SLOT_W-1:0] slot_addr_q, slot_addr_n;
  logic [31:0]       sprite_datas_q, sprite_datas_n;
  logic              sprite_on_q, sprite_on_n;
  logic              overflow_q, overflow_n;
  logic              busy_q, busy_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic [CNT_W-1:0]  idx_q, idx_n;
  logic [SCAN_W-1:0] scan_idx_q, scan_idx_n;
  logic [9:0]        line_y_q, line_y_n;
  logic [31:0]       entries [DEPTH];

  logic        eval, last_eval, visible, append, drop;
  logic [10:0] dy;
  logic [31:0] cur;
  logic [9:0]  cur_x;
  logic        stale, start, finish, advance, last_entry;

  // Read data lags the address by one cycle, so scan_idx_q-1 is the slot on slot_data.
  assign eval      = (state_q == SCAN) && (scan_idx_q != '0);
  assign last_eval = eval && (scan_idx_q == SCAN_W'(NUM_SLOTS));
  assign dy        = {1'b0, line_y_q} - {1'b0, bus.slot_data[18:9]};
  assign visible   = eval && bus.slot_data[29] && !dy[10] && (dy < 11'(SPRITE_SIZE));
  assign append    = visible && (count_q < CNT_W'(MAX_ACTIVE));
  assign drop      = visible && !append;

  assign cur        = entries[idx_q[IDX_W-1:0]];
  assign cur_x      = cur[28:19];
  assign stale      = (state_q == DRAW) && !sprite_on_q &&
                      ({1'b0, bus.pixel_x} >= ({1'b0, cur_x} + 11'(SPRITE_SIZE)));
  assign start      = (state_q == DRAW) && !sprite_on_q && !stale && (bus.pixel_x >= cur_x);
  assign finish     = (state_q == DRAW) && sprite_on_q && bus.counter_finished;
  assign advance    = stale || finish;
  assign last_entry = (idx_q + CNT_W'(1)) == count_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (bus.line_start) begin
      state_n = SCAN;
    end else begin
      case (state_q)
        SCAN: if (last_eval) state_n = ((count_q != '0) || append) ? DRAW : DONE;
        DRAW: if (advance && last_entry) state_n = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    slot_addr_n    = slot_addr_q;
    sprite_datas_n = sprite_datas_q;
    sprite_on_n    = sprite_on_q;
    overflow_n     = overflow_q;
    count_n        = count_q;
    idx_n          = idx_q;
    scan_idx_n     = scan_idx_q;
    line_y_n       = line_y_q;
    if (bus.line_start) begin
      line_y_n    = bus.line_y;
      count_n     = '0;
      idx_n       = '0;
      overflow_n  = 1'b0;
      sprite_on_n = 1'b0;
      slot_addr_n = '0;
      scan_idx_n  = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (scan_idx_q != SCAN_W'(NUM_SLOTS)) begin
            scan_idx_n = scan_idx_q + SCAN_W'(1);
            if (scan_idx_q < SCAN_W'(NUM_SLOTS - 1))
              slot_addr_n = SLOT_W'(scan_idx_q + SCAN_W'(1));
          end
          if (append) count_n = count_q + CNT_W'(1);
          if (drop)   overflow_n = 1'b1;
        end
        DRAW: begin
          if (start) begin
            sprite_on_n    = 1'b1;
            sprite_datas_n = cur;
          end
          if (finish)  sprite_on_n = 1'b0;
          if (advance) idx_n = idx_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
    busy_n = (state_n == SCAN) || (state_n == DRAW);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      slot_addr_q    <= '0;
      sprite_datas_q <= '0;
      sprite_on_q    <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      count_q        <= '0;
      idx_q          <= '0;
      scan_idx_q     <= '0;
      line_y_q       <= '0;
    end else begin
      slot_addr_q    <= slot_addr_n;
      sprite_datas_q <= sprite_datas_n;
      sprite_on_q    <= sprite_on_n;
      overflow_q     <= overflow_n;
      busy_q         <= busy_n;
      count_q        <= count_n;
      idx_q          <= idx_n;
      scan_idx_q     <= scan_idx_n;
      line_y_q       <= line_y_n;
    end
  end

  // Line buffer contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk_pixel) begin
    if (append) entries[count_q[IDX_W-1:0]] <= bus.slot_data;
  end

  assign bus.slot_addr    = slot_addr_q;
  assign bus.sprite_datas = sprite_datas_q;
  assign bus.sprite_on    = sprite_on_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = busy_q;
endmodule
